// File: rtl/tread_joy_mapper.sv
// tread_joy_mapper: joystick/analog to tank-tread control mapping with
// per-player tick-based debounce and analog hysteresis.

// Per-player channel: mapping, axis hysteresis and debounce.
module tjm_chan #(
  parameter int           DEB_TICKS = 4,
  parameter logic [7:0]   ANA_ON    = 8'd48,
  parameter logic [7:0]   ANA_OFF   = 8'd24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clr,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [3:0]  dig,
  input  logic [3:0]  dig2,
  input  logic [15:0] ana,
  output logic [3:0]  tread,
  output logic [3:0]  tread_nx
);
  localparam logic [7:0]        DEB  = 8'(DEB_TICKS);
  localparam logic signed [8:0] ON_P  = $signed({1'b0, ANA_ON});
  localparam logic signed [8:0] ON_N  = -ON_P;
  localparam logic signed [8:0] OFF_P = $signed({1'b0, ANA_OFF});
  localparam logic signed [8:0] OFF_N = -OFF_P;

  // axis state encoding: 00 = 0, 01 = +1, 11 = -1
  localparam logic [1:0] AX_Z = 2'b00, AX_P = 2'b01, AX_N = 2'b11;

  logic [3:0] pend, pend_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] ax, ay, ax_nx, ay_nx;
  logic [1:0] ax_new, ay_new;
  logic [3:0] cand, udlr;

  function automatic logic [3:0] map8(input logic [3:0] d);
    case (d)
      4'b1000: map8 = 4'b1010;
      4'b1010: map8 = 4'b0010;
      4'b1001: map8 = 4'b1000;
      4'b0001: map8 = 4'b1001;
      4'b0101: map8 = 4'b0100;
      4'b0100: map8 = 4'b0101;
      4'b0110: map8 = 4'b0001;
      4'b0010: map8 = 4'b0110;
      default: map8 = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] axis_step(input logic [7:0] v, input logic [1:0] st);
    logic signed [8:0] v9;
    v9 = $signed({v[7], v});
    if (v9 >= ON_P)                      axis_step = AX_P;
    else if (v9 <= ON_N)                 axis_step = AX_N;
    else if (v9 < OFF_P && v9 > OFF_N)   axis_step = AX_Z;
    else                                 axis_step = st;
  endfunction

  // candidate code for the current mode, analog using the updated axis state
  always_comb begin
    ax_new = axis_step(ana[7:0], ax);
    ay_new = axis_step(ana[15:8], ay);
    udlr   = {ay_new == AX_N, ay_new == AX_P, ax_new == AX_N, ax_new == AX_P};
    case (mode)
      2'd1:    cand = {dig[3] & ~dig[2], dig[2] & ~dig[3],
                       dig2[3] & ~dig2[2], dig2[2] & ~dig2[3]};
      2'd2:    cand = map8(udlr);
      default: cand = map8(dig);
    endcase
  end

  // next-state: mode change clears everything, otherwise evaluate on tick only
  always_comb begin
    pend_nx  = pend;
    cnt_nx   = cnt;
    ax_nx    = ax;
    ay_nx    = ay;
    tread_nx = tread;
    if (clr) begin
      pend_nx  = '0;
      cnt_nx   = '0;
      ax_nx    = AX_Z;
      ay_nx    = AX_Z;
      tread_nx = '0;
    end else if (tick) begin
      if (mode == 2'd2) begin
        ax_nx = ax_new;
        ay_nx = ay_new;
      end
      if (cand != pend) begin
        pend_nx = cand;
        cnt_nx  = 8'd1;
      end else begin
        cnt_nx  = (cnt >= DEB) ? DEB : cnt + 8'd1;
      end
      if (cnt_nx >= DEB) tread_nx = cand;
    end
  end

  // channel state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend  <= '0;
      cnt   <= '0;
      ax    <= AX_Z;
      ay    <= AX_Z;
      tread <= '0;
    end else begin
      pend  <= pend_nx;
      cnt   <= cnt_nx;
      ax    <= ax_nx;
      ay    <= ay_nx;
      tread <= tread_nx;
    end
  end
endmodule

module tread_joy_mapper #(
  parameter int         PLAYERS   = 2,
  parameter int         DEB_TICKS = 4,
  parameter logic [7:0] ANA_ON    = 8'd48,
  parameter logic [7:0] ANA_OFF   = 8'd24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    tick,
  input  logic [4*PLAYERS-1:0]    joy_dig,
  input  logic [4*PLAYERS-1:0]    joy_dig2,
  input  logic [16*PLAYERS-1:0]   joy_ana,
  output logic [4*PLAYERS-1:0]    tread,
  output logic                    changed
);
  logic [1:0] mode_q;
  logic       mode_chg;
  logic [1:0] mode_eff;
  logic [PLAYERS-1:0][3:0]  dig, dig2, tr, tr_nx;
  logic [PLAYERS-1:0][15:0] ana;

  assign mode_chg = (mode != mode_q);
  assign mode_eff = (mode == 2'd3) ? 2'd0 : mode;
  assign dig   = joy_dig;
  assign dig2  = joy_dig2;
  assign ana   = joy_ana;
  assign tread = tr;

  genvar p;
  generate
    for (p = 0; p < PLAYERS; p++) begin : g_ch
      tjm_chan #(.DEB_TICKS(DEB_TICKS), .ANA_ON(ANA_ON), .ANA_OFF(ANA_OFF)) u_ch (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .clr      (mode_chg),
        .tick     (tick),
        .mode     (mode_eff),
        .dig      (dig[p]),
        .dig2     (dig2[p]),
        .ana      (ana[p]),
        .tread    (tr[p]),
        .tread_nx (tr_nx[p])
      );
    end
  endgenerate

  // mode copy and single change pulse covering all channels
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q  <= mode;
      changed <= 1'b0;
    end else begin
      mode_q  <= mode;
      changed <= (tr_nx != tr);
    end
  end
endmodule

// File: tb/tb_tread_joy_mapper.sv
// Directed self-checking bench for tread_joy_mapper (PLAYERS=2, DEB_TICKS=4).
module tb_tread_joy_mapper;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        tick;
  logic [7:0]  joy_dig, joy_dig2, tread;
  logic [31:0] joy_ana;
  logic        changed;

  int checks = 0, failures = 0, chg_cnt = 0;

  tread_joy_mapper #(.PLAYERS(2), .DEB_TICKS(4), .ANA_ON(8'd48), .ANA_OFF(8'd24)) dut (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .tick(tick),
    .joy_dig(joy_dig), .joy_dig2(joy_dig2), .joy_ana(joy_ana),
    .tread(tread), .changed(changed)
  );

  always #5 clk_sys = ~clk_sys;

  // count cycles in which changed is high
  always @(negedge clk_sys) if (changed) chg_cnt = chg_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk_sys);
      tick = 1'b0;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; tick = 1'b0;
    joy_dig = '0; joy_dig2 = '0; joy_ana = '0;
    idle(3);
    chk("rst_tread", {24'd0, tread}, 32'd0);
    chk("rst_changed", {31'd0, changed}, 32'd0);
    reset = 1'b0;
    idle(2);

    // mapping and debounce: U -> 1010 after 4th tick
    chg_cnt = 0;
    joy_dig = 8'h08;
    ticks(3);
    chk("deb_3", {24'd0, tread}, 32'h00);
    ticks(1);
    chk("u_map", {24'd0, tread}, 32'h0A);
    idle(2);
    chk("u_chg", chg_cnt, 32'd1);
    // L -> 0110
    joy_dig = 8'h02;
    ticks(3);
    chk("l_deb3", {24'd0, tread}, 32'h0A);
    ticks(1);
    chk("l_map", {24'd0, tread}, 32'h06);
    joy_dig = 8'h00;
    ticks(4);
    chk("none_map", {24'd0, tread}, 32'h00);

    // glitch: U for 3 ticks then release
    idle(2);
    chg_cnt = 0;
    joy_dig = 8'h08;
    ticks(3);
    joy_dig = 8'h00;
    ticks(4);
    chk("glitch_tread", {24'd0, tread}, 32'h00);
    chk("glitch_chg", chg_cnt, 32'd0);
    // U+D -> none
    joy_dig = 8'h0C;
    ticks(4);
    chk("ud_map", {24'd0, tread}, 32'h00);
    chk("ud_chg", chg_cnt, 32'd0);

    // reserved mode 3 behaves as 8-way: D+R -> 0100
    mode = 2'd3;
    idle(2);
    joy_dig = 8'h05;
    ticks(4);
    chk("m3_dr", {24'd0, tread}, 32'h04);

    // dual stick
    mode = 2'd1;
    idle(2);
    chk("m1_clr", {24'd0, tread}, 32'h00);
    joy_dig = 8'h08; joy_dig2 = 8'h04;
    ticks(4);
    chk("dual_ud", {24'd0, tread}, 32'h09);
    joy_dig2 = 8'h0C;
    ticks(4);
    chk("dual_upd", {24'd0, tread}, 32'h08);
    joy_dig2 = 8'h08;
    ticks(4);
    chk("dual_uu", {24'd0, tread}, 32'h0A);

    // mode change coinciding with a tick
    idle(2);
    chg_cnt = 0;
    mode = 2'd2; tick = 1'b1;
    @(negedge clk_sys);
    tick = 1'b0;
    chk("mchg_tread", {24'd0, tread}, 32'h00);
    idle(2);
    chk("mchg_chg", chg_cnt, 32'd1);

    // analog hysteresis on X
    joy_dig = '0; joy_dig2 = '0;
    joy_ana = 32'h0000_0032;       // X = 50
    ticks(4);
    chk("ana_50", {24'd0, tread}, 32'h09);
    joy_ana = 32'h0000_001E;       // X = 30, in band
    ticks(4);
    chk("ana_30", {24'd0, tread}, 32'h09);
    joy_ana = 32'h0000_0014;       // X = 20, releases
    ticks(3);
    chk("ana_20_d3", {24'd0, tread}, 32'h09);
    ticks(1);
    chk("ana_20", {24'd0, tread}, 32'h00);
    joy_ana = 32'h0000_0080;       // X = -128
    ticks(4);
    chk("ana_m128", {24'd0, tread}, 32'h06);
    joy_ana = 32'h0000_C400;       // Y = -60, X = 0 -> U
    ticks(4);
    chk("ana_up", {24'd0, tread}, 32'h0A);

    // reset mid-debounce
    joy_ana = 32'h0000_0032;
    ticks(2);
    reset = 1'b1;
    idle(2);
    chk("rst2_tread", {24'd0, tread}, 32'h00);
    chk("rst2_chg", {31'd0, changed}, 32'd0);
    reset = 1'b0;
    idle(1);
    ticks(3);
    chk("reacq_3", {24'd0, tread}, 32'h00);
    ticks(1);
    chk("reacq_4", {24'd0, tread}, 32'h09);

    // multi-player simultaneous update
    joy_ana = '0;
    mode = 2'd0;
    idle(2);
    chk("mp_clr", {24'd0, tread}, 32'h00);
    idle(2);
    chg_cnt = 0;
    joy_dig = 8'h18;               // P1 = R, P0 = U
    ticks(3);
    chk("mp_d3", {24'd0, tread}, 32'h00);
    ticks(1);
    chk("mp_both", {24'd0, tread}, 32'h9A);
    idle(2);
    chk("mp_chg", chg_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
